bnn_xnor_pop_acc: RTL and testbench
===================================

Name: bnn_xnor_pop_acc

Overview:
- Parametrised binary-MAC popcount accumulator, successor to the fixed 8-bit popcount lookup.
- Per beat, XNORs an activation vector with a weight vector and computes score = 2*popcount(xnor) - VEC_W. The score is exact, including the +VEC_W case.
- Accumulates signed scores across a multi-beat dot product terminated by in_last, then emits one signed result.
- Sits between the binary activation/weight fetch and the threshold/batch-norm stage of the BMAC datapath.

Parameters:
- VEC_W, 64, bits per beat. Multiple of 8, range 8..1024.
- ACC_W, 16, accumulator and result width (signed). Must be >= clog2(VEC_W)+2.
- Derived: SCORE_W = clog2(VEC_W)+2, the signed per-beat score width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- in_act  in  VEC_W  binary activations (1 = +1, 0 = -1)
- in_wgt  in  VEC_W  binary weights (same encoding)
- in_last  in  1  final beat of the dot product
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  signed dot-product result
- busy  out  1  beats in pipeline or accumulator nonzero-in-progress

Behaviour:
- Reset (async, immediate): all pipeline valids = 0, acc = 0, out_valid = 0, out_data = 0, busy = 0. in_ready = 1 once rst deasserts.
- Accept rule: a beat is accepted when in_valid && in_ready.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall. While stalled, every pipeline register holds its value.
- S1 (register):
  - x = ~(in_act ^ in_wgt).
  - Per-byte popcount, 4 bits unsigned, range 0..8. Use the unsigned count, not the 4-bit signed table, to avoid the 8 -> -8 wrap.
  - Register byte counts, valid, last.
- S2 (register):
  - Adder tree over VEC_W/8 byte counts gives pop, range 0..VEC_W.
  - score = (pop << 1) - VEC_W, SCORE_W signed.
  - Register score, valid, last.
- S3 (accumulate):
  - If S2 valid && !last: acc <= acc + sext(score).
  - If S2 valid && last: out_data <= acc + sext(score), out_valid <= 1, acc <= 0.
  - Arithmetic wraps modulo 2^ACC_W unless the saturation macro is defined.
- Latency: last beat accepted at cycle t -> out_valid high at t+3 (no stall). Throughput is one beat per cycle.
- out_valid stays high, and out_data stays stable, until out_ready. It clears the cycle after the handshake, unless a new last completes in that same cycle; in that case it stays 1 and out_data updates (back-to-back results).
- Single-beat dot product: a beat with in_last = 1 is valid; the result is that beat's score.
- Beats with in_valid = 0 are bubbles. acc is retained across bubbles indefinitely.
- busy = any stage valid || acc-in-progress flag. The flag sets on a non-last beat reaching S3 and clears when the last beat reaches S3.
- Reset mid-operation discards the partial acc and all in-flight beats; no result is emitted.
- out_ready with out_valid = 0 is ignored.

Optional Feature:
- Macro: BMAC_POP_ACC_SAT_EN.
- Defined:
  - S3 addition saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - A sticky sat flag is carried per dot product and appended as out_sat (out, 1), valid with out_valid.
  - sat clears when the result is consumed.
- Undefined: two's-complement wrap; the out_sat port is absent.

Test Plan:
- Single beat, VEC_W=64: in_act = in_wgt = 64'h0123_4567_89AB_CDEF, in_last = 1 -> out_data = +64 at t+3.
- Single beat: in_act = 0, in_wgt = all ones, last -> out_data = -64. in_act = 64'h00000000_FFFFFFFF, in_wgt = 0 -> out_data = 0.
- Four back-to-back beats of +64 with last on the 4th, then immediately 2 beats of -64 with last on the 2nd -> results +256, then -128, with no bubble between the two dot products.
- Hold out_ready = 0 for 5 cycles while results complete:
  - in_ready drops and out_data is held.
  - On release, results are delivered in order with none lost or duplicated.
- Assert rst for 1 cycle after 2 non-last beats -> out_valid = 0, busy = 0. A new single beat of +64 with last -> +64, with no residue from before reset.
- With BMAC_POP_ACC_SAT_EN, ACC_W = 8, VEC_W = 64: three beats of +64, last on the 3rd -> out_data = 127, out_sat = 1. Without the macro -> out_data = -64 (192 wrapped).

Source files
------------

// File: rtl/bnn_xnor_pop_acc.sv
// bnn_xnor_pop_acc: binary-MAC XNOR/popcount accumulator.
// Each beat produces score = 2*popcount(~(act ^ wgt)) - VEC_W. Scores are
// summed until in_last, then one signed result is emitted.
// Three stages: S1 byte popcounts, S2 adder tree and score, S3 accumulate.
// Optional feature macro: BMAC_POP_ACC_SAT_EN. When defined, S3 saturates
// and a sticky out_sat flag is emitted with each result. When undefined,
// S3 wraps in two's complement and out_sat does not exist.
module bnn_xnor_pop_acc #(
  parameter int VEC_W = 64,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VEC_W-1:0]        in_act,
  input  logic [VEC_W-1:0]        in_wgt,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
`ifdef BMAC_POP_ACC_SAT_EN
  output logic                    out_sat,
`endif
  output logic                    busy
);

  localparam int NB      = VEC_W / 8;
  localparam int POP_W   = $clog2(VEC_W) + 1;
  localparam int SCORE_W = $clog2(VEC_W) + 2;
  localparam logic signed [SCORE_W-1:0] VEC_S = SCORE_W'(VEC_W);

  // Unsigned popcount of one byte (0..8); a 4-bit signed table would wrap 8 to -8.
  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, b[i]};
    end
    return c;
  endfunction

  logic                      advance;
  logic [VEC_W-1:0]          xnor_vec;
  logic [NB*4-1:0]           byte_cnt;
  logic                      s1_valid;
  logic                      s1_last;
  logic [NB*4-1:0]           s1_cnt;
  logic [POP_W-1:0]          pop;
  logic signed [SCORE_W-1:0] score;
  logic                      s2_valid;
  logic                      s2_last;
  logic signed [SCORE_W-1:0] s2_score;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic                      in_prog;

  // The whole pipeline freezes while a result waits for the consumer.
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;
  assign busy     = s1_valid | s2_valid | in_prog;
  assign xnor_vec = ~(in_act ^ in_wgt);

  // Per-byte popcounts of the XNOR vector.
  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < NB; i++) begin
      byte_cnt[i*4 +: 4] = pop8(xnor_vec[i*8 +: 8]);
    end
  end

  // S1 register: byte counts plus beat control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_cnt   <= byte_cnt;
    end
  end

  // Adder tree over the byte counts, then map pop 0..VEC_W to score -VEC_W..+VEC_W.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NB; i++) begin
      pop = pop + POP_W'(s1_cnt[i*4 +: 4]);
    end
    score = $signed({pop, 1'b0}) - VEC_S;
  end

  // S2 register: signed score plus beat control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_score <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_score <= score;
    end
  end

`ifdef BMAC_POP_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;
  logic                  acc_sat;

  // Saturating accumulate: one guard bit detects overflow, then clamp.
  always_comb begin
    sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(s2_score);
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (ovf) begin
      sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_wide[ACC_W-1:0];
    end
  end

  // Sticky saturation flag per dot product; out_sat clears once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sat <= 1'b0;
      out_sat <= 1'b0;
    end else if (advance) begin
      if (s2_valid && s2_last) begin
        out_sat <= acc_sat | ovf;
        acc_sat <= 1'b0;
      end else begin
        out_sat <= 1'b0;
        if (s2_valid) begin
          acc_sat <= acc_sat | ovf;
        end
      end
    end
  end
`else
  // Wrapping accumulate in ACC_W-bit two's complement.
  always_comb begin
    sum = acc + ACC_W'(s2_score);
  end
`endif

  // S3: accumulate, or emit the result on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      in_prog   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s2_valid & s2_last;
      if (s2_valid && s2_last) begin
        out_data <= sum;
        acc      <= '0;
        in_prog  <= 1'b0;
      end else if (s2_valid) begin
        acc      <= sum;
        in_prog  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bnn_xnor_pop_acc.sv
// Directed, table-driven bench for bnn_xnor_pop_acc (VEC_W=64). A second
// instance with ACC_W=8 shares the inputs to observe wrap or saturation.
module tb_bnn_xnor_pop_acc;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in_act;
  logic [63:0]        in_wgt;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               busy;
  logic               in_ready8;
  logic               out_valid8;
  logic signed [7:0]  out_data8;
  logic               busy8;
`ifdef BMAC_POP_ACC_SAT_EN
  logic               out_sat;
  logic               out_sat8;
`endif

  int checks = 0;
  int errors = 0;
  int got[$];
  int got8[$];
`ifdef BMAC_POP_ACC_SAT_EN
  int gotsat[$];
  int gotsat8[$];
`endif

  typedef struct {
    logic [63:0] act;
    logic [63:0] wgt;
    int          exp;
  } vec_t;
  vec_t tbl[8];

  localparam logic [63:0] ZERO = 64'h0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  bnn_xnor_pop_acc #(.VEC_W(64), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BMAC_POP_ACC_SAT_EN
    .out_sat(out_sat),
`endif
    .busy(busy)
  );

  bnn_xnor_pop_acc #(.VEC_W(64), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
`ifdef BMAC_POP_ACC_SAT_EN
    .out_sat(out_sat8),
`endif
    .busy(busy8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every completed handshake (out_ready only changes just after posedge).
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got.push_back(int'(out_data));
`ifdef BMAC_POP_ACC_SAT_EN
      gotsat.push_back(int'(out_sat));
`endif
    end
    if (out_valid8 && out_ready) begin
      got8.push_back(int'(out_data8));
`ifdef BMAC_POP_ACC_SAT_EN
      gotsat8.push_back(int'(out_sat8));
`endif
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_got(input string nm, input int idx, input int exp);
    if (got.size() > idx) chk(nm, got[idx], exp);
    else chk({nm, " missing"}, got.size(), idx + 1);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] a, input logic [63:0] w, input logic last);
    int k;
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    in_last  = last;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", k, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("result_count", got.size(), n);
  endtask

  initial begin
    tbl[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,  64};
    tbl[1] = '{ZERO,                    ONES,                   -64};
    tbl[2] = '{64'h0000_0000_FFFF_FFFF, ZERO,                     0};
    tbl[3] = '{64'h0000_0000_0000_0001, ZERO,                    62};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFE, ZERO,                   -62};
    tbl[5] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, -64};
    tbl[6] = '{64'h0000_0000_0000_FFFF, ZERO,                    32};
    tbl[7] = '{64'h00FF_00FF_00FF_00FF, 64'h00FF_00FF_00FF_00FF,  64};

    rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single-beat dot products: latency of exactly three edges.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_act = tbl[i].act; in_wgt = tbl[i].wgt; in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk($sformatf("t%0d_busy", i), int'(busy), 1);
      chk($sformatf("t%0d_early1", i), int'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("t%0d_early2", i), int'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("t%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("t%0d_data", i), int'(out_data), tbl[i].exp);
      @(negedge clk);
      chk($sformatf("t%0d_clear", i), int'(out_valid), 0);
    end

    // Back-to-back dot products with no input bubble.
    got.delete();
    for (int i = 0; i < 4; i++) send_beat(ZERO, ZERO, i == 3);
    for (int i = 0; i < 2; i++) send_beat(ZERO, ONES, i == 1);
    wait_results(2);
    chk_got("b2b_first", 0, 256);
    chk_got("b2b_second", 1, -128);

    // Accumulator retained across bubbles.
    got.delete();
    send_beat(ZERO, ZERO, 1'b0);
    repeat (4) @(negedge clk);
    chk("bubble_busy", int'(busy), 1);
    send_beat(ZERO, ZERO, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(ZERO, ONES, 1'b1);
    wait_results(1);
    chk_got("bubble_result", 0, 64);
    chk("bubble_idle_busy", int'(busy), 0);

    // Backpressure: results held while out_ready is low, then drained in order.
    got.delete();
    out_ready = 1'b0;
    fork
      begin
        send_beat(ZERO, ZERO, 1'b1);
        send_beat(ZERO, ONES, 1'b1);
        send_beat(ZERO, ZERO, 1'b0);
        send_beat(ZERO, ZERO, 1'b1);
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_in_ready8", int'(in_ready8), 0);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), 64);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_results(3);
    chk_got("stall_r0", 0, 64);
    chk_got("stall_r1", 1, -64);
    chk_got("stall_r2", 2, 128);

    // Reset in the middle of a dot product discards everything.
    got.delete();
    send_beat(ZERO, ZERO, 1'b0);
    send_beat(ZERO, ZERO, 1'b0);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_none", got.size(), 0);
    chk("post_rst_busy", int'(busy), 0);
    send_beat(ZERO, ZERO, 1'b1);
    wait_results(1);
    chk_got("post_rst_result", 0, 64);

    // Overflow of the 8-bit instance: 3 x +64 = 192.
    got.delete();
    got8.delete();
`ifdef BMAC_POP_ACC_SAT_EN
    gotsat.delete();
    gotsat8.delete();
`endif
    for (int i = 0; i < 3; i++) send_beat(ZERO, ZERO, i == 2);
    wait_results(1);
    chk_got("ovf_wide", 0, 192);
    chk("ovf8_count", got8.size(), 1);
    if (got8.size() > 0) begin
`ifdef BMAC_POP_ACC_SAT_EN
      chk("ovf8_sat_data", got8[0], 127);
      chk("ovf8_sat_flag", gotsat8[0], 1);
      chk("ovf_wide_flag", gotsat[0], 0);
      chk("ovf8_flag_cleared", int'(out_sat8), 0);
`else
      chk("ovf8_wrap_data", got8[0], -64);
`endif
    end
    chk("end_busy8", int'(busy8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
